// File: rtl/echo_store_forward.sv
// Store-and-forward frame buffer for the echo path.
// Frames are released only once complete; overflowing frames are dropped.
module echo_store_forward #(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        s_axis_TVALID,
    output logic        s_axis_TREADY,
    input  logic [63:0] s_axis_TDATA,
    input  logic [7:0]  s_axis_TKEEP,
    input  logic        s_axis_TLAST,
    output logic        m_axis_TVALID,
    input  logic        m_axis_TREADY,
    output logic [63:0] m_axis_TDATA,
    output logic [7:0]  m_axis_TKEEP,
    output logic        m_axis_TLAST,
    output logic [15:0] drop_cnt,
    output logic        drop_pulse
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int W = 73;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    localparam ptr_t ONE = ptr_t'(1);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;
    logic [W-1:0] out_q;

    ptr_t wr_q, wr_d;
    ptr_t commit_q, commit_d;
    ptr_t rd_q;
    ptr_t fetch_q;
    logic bad_q, bad_d;
    logic rdy_q;
    logic rvalid_q;
    logic ovalid_q;
    logic [15:0] cnt_q, cnt_d;
    logic pulse_q;

    logic s_fire, full, wr_en, drop;
    logic m_fire, out_load, rd_en;

    assign s_fire = s_axis_TVALID & rdy_q;
    // rd_q frees space only when a beat leaves m_axis, so prefetched
    // words still count as occupied.
    assign full   = ((wr_q + ONE) == rd_q);
    assign wr_en  = s_fire & ~bad_q & ~full;
    assign drop   = s_fire & s_axis_TLAST & (bad_q | full);

    assign m_fire   = ovalid_q & m_axis_TREADY;
    assign out_load = ~ovalid_q | m_axis_TREADY;
    assign rd_en    = (fetch_q != commit_q) & (~rvalid_q | out_load);

    always_comb begin
        wr_d     = wr_q;
        commit_d = commit_q;
        bad_d    = bad_q;
        cnt_d    = cnt_q;
        if (wr_en) begin
            wr_d = wr_q + ONE;
            if (s_axis_TLAST) begin
                commit_d = wr_q + ONE;
            end
        end
        if (s_fire) begin
            if (s_axis_TLAST) begin
                bad_d = 1'b0;
            end else if (full) begin
                bad_d = 1'b1;
            end
        end
        if (drop) begin
            wr_d = commit_q;
            if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem_q[wr_q] <= {s_axis_TDATA, s_axis_TKEEP, s_axis_TLAST};
        end
    end

    always_ff @(posedge aclk) begin
        if (rd_en) begin
            rdata_q <= mem_q[fetch_q];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rdy_q    <= 1'b0;
            wr_q     <= '0;
            commit_q <= '0;
            rd_q     <= '0;
            fetch_q  <= '0;
            bad_q    <= 1'b0;
            rvalid_q <= 1'b0;
            ovalid_q <= 1'b0;
            out_q    <= '0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
        end else begin
            rdy_q    <= 1'b1;
            wr_q     <= wr_d;
            commit_q <= commit_d;
            bad_q    <= bad_d;
            cnt_q    <= cnt_d;
            pulse_q  <= drop;
            if (rd_en) begin
                fetch_q  <= fetch_q + ONE;
                rvalid_q <= 1'b1;
            end else if (out_load) begin
                rvalid_q <= 1'b0;
            end
            if (out_load) begin
                ovalid_q <= rvalid_q;
                if (rvalid_q) begin
                    out_q <= rdata_q;
                end
            end
            if (m_fire) begin
                rd_q <= rd_q + ONE;
            end
        end
    end

    assign s_axis_TREADY = rdy_q;
    assign m_axis_TVALID = ovalid_q;
    assign m_axis_TDATA  = out_q[72:9];
    assign m_axis_TKEEP  = out_q[8:1];
    assign m_axis_TLAST  = out_q[0];
    assign drop_cnt      = cnt_q;
    assign drop_pulse    = pulse_q;

endmodule

// File: tb/tb_echo_store_forward.sv
// Directed bench for echo_store_forward with a 15-word buffer.
module tb_echo_store_forward;
    typedef logic [72:0] beat_t;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [63:0] s_data = '0;
    logic [7:0]  s_keep = '0;
    logic        s_last = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [63:0] m_data;
    logic [7:0]  m_keep;
    logic        m_last;
    logic [15:0] drop_cnt;
    logic        drop_pulse;

    int    checks = 0;
    int    errors = 0;
    beat_t q_exp[$];
    beat_t q_out[$];
    logic  rand_rdy = 1'b0;
    logic  stall_pend = 1'b0;
    beat_t held = '0;

    echo_store_forward #(.DEPTH_LOG2(4)) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .s_axis_TVALID(s_valid),
        .s_axis_TREADY(s_ready),
        .s_axis_TDATA(s_data),
        .s_axis_TKEEP(s_keep),
        .s_axis_TLAST(s_last),
        .m_axis_TVALID(m_valid),
        .m_axis_TREADY(m_ready),
        .m_axis_TDATA(m_data),
        .m_axis_TKEEP(m_keep),
        .m_axis_TLAST(m_last),
        .drop_cnt(drop_cnt),
        .drop_pulse(drop_pulse)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        if (rand_rdy) m_ready = 1'($urandom_range(0, 1));
        @(negedge aclk);
        if (stall_pend && aresetn) begin
            checks++;
            if ({m_valid, m_data, m_keep, m_last} !== {1'b1, held}) begin
                errors++;
                $display("FAIL stall_hold got %b_%h exp 1_%h",
                         m_valid, {m_data, m_keep, m_last}, held);
            end
        end
        stall_pend = aresetn && m_valid && !m_ready;
        held = {m_data, m_keep, m_last};
        if (m_valid && m_ready) q_out.push_back(held);
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input int len, input logic [63:0] base,
                        input bit keep_it);
        for (int i = 0; i < len; i++) begin
            s_valid = 1'b1;
            s_data  = base + 64'(i);
            s_keep  = (i == len - 1) ? 8'h0F : 8'hFF;
            s_last  = (i == len - 1);
            if (keep_it) q_exp.push_back({s_data, s_keep, s_last});
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain(input int n, input int budget);
        for (int k = 0; k < budget && q_out.size() < n; k++) tick();
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        checks++;
        if ({s_ready, m_valid, m_data, m_keep, m_last} !== 75'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b %b %h %h %b exp all 0",
                     s_ready, m_valid, m_data, m_keep, m_last);
        end
        checks++;
        if ({drop_cnt, drop_pulse} !== 17'd0) begin
            errors++;
            $display("FAIL reset_drop got %h %b exp 0 0", drop_cnt, drop_pulse);
        end
        aresetn = 1'b1;
        tick();
        tick();
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got %b exp 1", s_ready);
        end
    endtask

    task automatic test_basic();
        logic [63:0] b;
        b = 64'hA000_0000_0000_0000;
        q_out.delete();
        q_exp.delete();
        m_ready = 1'b1;
        send(4, b, 1'b0);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_n got %b exp 0", m_valid);
        end
        tick();
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_n1 got %b exp 0", m_valid);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({m_valid, m_data, m_keep, m_last} !==
                {1'b1, b + 64'(i), (i == 3) ? 8'h0F : 8'hFF, i == 3}) begin
                errors++;
                $display("FAIL basic_beat%0d got %b %h %h %b", i,
                         m_valid, m_data, m_keep, m_last);
            end
            tick();
        end
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_end got %b exp 0", m_valid);
        end
    endtask

    task automatic test_overflow();
        int lasts;
        q_out.delete();
        q_exp.delete();
        m_ready = 1'b0;
        send(5, 64'h1111_0000_0000_0000, 1'b1);
        send(5, 64'h2222_0000_0000_0000, 1'b1);
        send(5, 64'h3333_0000_0000_0000, 1'b1);
        checks++;
        if (drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL ovf_nodrop got %0d exp 0", drop_cnt);
        end
        checks++;
        if ({m_valid, m_data} !== {1'b1, 64'h1111_0000_0000_0000}) begin
            errors++;
            $display("FAIL ovf_head got %b %h exp 1 1111000000000000",
                     m_valid, m_data);
        end
        send(2, 64'h4444_0000_0000_0000, 1'b0);
        checks++;
        if ({drop_cnt, drop_pulse} !== {16'd1, 1'b1}) begin
            errors++;
            $display("FAIL ovf_drop got %0d %b exp 1 1", drop_cnt, drop_pulse);
        end
        tick();
        checks++;
        if (drop_pulse !== 1'b0) begin
            errors++;
            $display("FAIL ovf_pulse_len got %b exp 0", drop_pulse);
        end
        m_ready = 1'b1;
        drain(15, 40);
        repeat (5) tick();
        checks++;
        if (q_out.size() != 15) begin
            errors++;
            $display("FAIL ovf_count got %0d exp 15", q_out.size());
        end
        lasts = 0;
        for (int i = 0; i < 15 && i < q_out.size(); i++) begin
            lasts += int'(q_out[i][0]);
            checks++;
            if (q_out[i] !== q_exp[i]) begin
                errors++;
                $display("FAIL ovf_beat%0d got %h exp %h", i, q_out[i], q_exp[i]);
            end
        end
        checks++;
        if (lasts != 3) begin
            errors++;
            $display("FAIL ovf_lasts got %0d exp 3", lasts);
        end
    endtask

    task automatic test_long();
        q_out.delete();
        q_exp.delete();
        m_ready = 1'b1;
        send(20, 64'h5555_0000_0000_0000, 1'b0);
        repeat (4) tick();
        checks++;
        if (drop_cnt !== 16'd2 || q_out.size() != 0) begin
            errors++;
            $display("FAIL long_drop got cnt %0d out %0d exp 2 0",
                     drop_cnt, q_out.size());
        end
        send(3, 64'h6666_0000_0000_0000, 1'b1);
        drain(3, 20);
        repeat (3) tick();
        checks++;
        if (q_out.size() != 3) begin
            errors++;
            $display("FAIL long_next_count got %0d exp 3", q_out.size());
        end
        for (int i = 0; i < 3 && i < q_out.size(); i++) begin
            checks++;
            if (q_out[i] !== q_exp[i]) begin
                errors++;
                $display("FAIL long_beat%0d got %h exp %h", i, q_out[i], q_exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int sent;
        int len;
        int k;
        q_out.delete();
        q_exp.delete();
        sent = 0;
        rand_rdy = 1'b1;
        for (int f = 0; f < 12; f++) begin
            len = (f * 7) % 10 + 1;
            k = 0;
            while (sent - q_out.size() + len > 15 && k < 200) begin
                tick();
                k++;
            end
            if (k >= 200) begin
                checks++;
                errors++;
                $display("FAIL b2b_space_timeout got %0d exp <200", k);
            end
            send(len, {32'(f), 32'h0}, 1'b1);
            sent += len;
        end
        drain(sent, 600);
        rand_rdy = 1'b0;
        m_ready = 1'b1;
        repeat (4) tick();
        checks++;
        if (q_out.size() != q_exp.size()) begin
            errors++;
            $display("FAIL b2b_count got %0d exp %0d", q_out.size(), q_exp.size());
        end
        for (int i = 0; i < q_exp.size() && i < q_out.size(); i++) begin
            checks++;
            if (q_out[i] !== q_exp[i]) begin
                errors++;
                $display("FAIL b2b_beat%0d got %h exp %h", i, q_out[i], q_exp[i]);
            end
        end
        checks++;
        if (drop_cnt !== 16'd2) begin
            errors++;
            $display("FAIL b2b_nodrop got %0d exp 2", drop_cnt);
        end
    endtask

    task automatic test_reset_mid();
        q_out.delete();
        q_exp.delete();
        m_ready = 1'b0;
        send(3, 64'h7777_0000_0000_0000, 1'b0);
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1;
            s_last  = 1'b0;
            s_keep  = 8'hFF;
            s_data  = 64'h8888_0000_0000_0000 + 64'(i);
            tick();
        end
        checks++;
        if (m_valid !== 1'b1) begin
            errors++;
            $display("FAIL rmid_pending got %b exp 1", m_valid);
        end
        aresetn = 1'b0;
        s_valid = 1'b0;
        #1;
        checks++;
        if ({s_ready, m_valid, m_data, m_keep, m_last, drop_cnt} !== 91'd0) begin
            errors++;
            $display("FAIL rmid_zero got %b %b %h %h %b %h exp all 0",
                     s_ready, m_valid, m_data, m_keep, m_last, drop_cnt);
        end
        repeat (2) tick();
        aresetn = 1'b1;
        m_ready = 1'b1;
        repeat (10) tick();
        checks++;
        if (q_out.size() != 0) begin
            errors++;
            $display("FAIL rmid_leak got %0d exp 0", q_out.size());
        end
        send(2, 64'h9999_0000_0000_0000, 1'b1);
        drain(2, 20);
        repeat (3) tick();
        checks++;
        if (q_out.size() != 2) begin
            errors++;
            $display("FAIL rmid_new_count got %0d exp 2", q_out.size());
        end
        for (int i = 0; i < 2 && i < q_out.size(); i++) begin
            checks++;
            if (q_out[i] !== q_exp[i]) begin
                errors++;
                $display("FAIL rmid_beat%0d got %h exp %h", i, q_out[i], q_exp[i]);
            end
        end
    endtask

    task automatic test_saturate();
        aresetn = 1'b0;
        repeat (2) tick();
        aresetn = 1'b1;
        repeat (2) tick();
        q_out.delete();
        q_exp.delete();
        m_ready = 1'b0;
        for (int f = 0; f < 3; f++) send(5, {32'hCC00 + 32'(f), 32'h0}, 1'b1);
        s_valid = 1'b1;
        s_last  = 1'b1;
        s_keep  = 8'h01;
        repeat (65534) tick();
        checks++;
        if (drop_cnt !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_pre got %h exp fffe", drop_cnt);
        end
        repeat (3) tick();
        checks++;
        if ({drop_cnt, drop_pulse} !== {16'hFFFF, 1'b1}) begin
            errors++;
            $display("FAIL sat_hold got %h %b exp ffff 1", drop_cnt, drop_pulse);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (2) tick();
        checks++;
        if (drop_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_stay got %h exp ffff", drop_cnt);
        end
        m_ready = 1'b1;
        drain(15, 40);
        repeat (3) tick();
        checks++;
        if (q_out.size() != 15) begin
            errors++;
            $display("FAIL sat_data_count got %0d exp 15", q_out.size());
        end
        for (int i = 0; i < 15 && i < q_out.size(); i++) begin
            checks++;
            if (q_out[i] !== q_exp[i]) begin
                errors++;
                $display("FAIL sat_beat%0d got %h exp %h", i, q_out[i], q_exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_long();
        test_back_to_back();
        test_reset_mid();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
